// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives pc to program memory and registers the returned word for decode.
// Optional FETCH_BOUNDS_CHECK_EN adds a fault output and FAULT state for pc beyond PROG_DEPTH.
module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter int          PROG_DEPTH  = 255,
  parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic [39:0] fetched_instruction,
  output logic [15:0] pc,
  output logic [39:0] instr,
  output logic [15:0] instr_pc,
  output logic        instr_valid,
  output logic        halted,
  output logic [15:0] fetch_count,
`ifdef FETCH_BOUNDS_CHECK_EN
  output logic        fault,
`endif
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
`ifdef FETCH_BOUNDS_CHECK_EN
    ,FAULT = 2'd3
`endif
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [39:0] instr_q, instr_d;
  logic [15:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;
  logic [15:0] count_q, count_d;
  logic        is_halt;

  assign is_halt = (fetched_instruction[39:32] == HALT_OPCODE);

`ifdef FETCH_BOUNDS_CHECK_EN
  localparam logic [16:0] PROG_END = 17'(PROG_DEPTH);
  logic fault_q, fault_d;
  logic out_of_range;
  assign out_of_range = ({1'b0, pc_q} >= PROG_END);
  assign fault        = fault_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= BOOT;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      count_q  <= count_d;
`ifdef FETCH_BOUNDS_CHECK_EN
      fault_q  <= fault_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    count_d  = count_q;
`ifdef FETCH_BOUNDS_CHECK_EN
    fault_d  = fault_q;
`endif
    case (state_q)
      // Bubble cycle so program memory is loaded before the first fetch.
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          valid_d = 1'b0;
        end else if (!stall) begin
`ifdef FETCH_BOUNDS_CHECK_EN
          if (out_of_range) begin
            state_d = FAULT;
            fault_d = 1'b1;
            valid_d = 1'b0;
          end else
`endif
          begin
            instr_d = fetched_instruction;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            // HALT is issued to decode but pc parks on its address.
            if (is_halt) begin
              state_d  = HALTED;
              halted_d = 1'b1;
            end else begin
              pc_d = pc_q + 16'd1;
            end
          end
        end
      end
      HALTED: begin
        if (redirect_valid) begin
          pc_d     = redirect_pc;
          halted_d = 1'b0;
          valid_d  = 1'b0;
          state_d  = RUN;
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end
`ifdef FETCH_BOUNDS_CHECK_EN
      FAULT: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          fault_d = 1'b0;
          valid_d = 1'b0;
          state_d = RUN;
        end
      end
`endif
      default: state_d = BOOT;
    endcase
  end

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign halted      = halted_q;
  assign fetch_count = count_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational program-memory model and an expected-output queue.
// Build with FETCH_BOUNDS_CHECK_EN defined to exercise the fault path instead of pc wrap.
module tb_fetch_unit;
  localparam int W = 57;  // {valid, instr_pc, instr}

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic [39:0] fetched_instruction;
  logic [15:0] pc;
  logic [39:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        halted;
  logic [15:0] fetch_count;
  logic [1:0]  fsm_state;
`ifdef FETCH_BOUNDS_CHECK_EN
  logic        fault;
`endif

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;

  fetch_unit dut (
    .clk                 (clk),
    .reset               (reset),
    .stall               (stall),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .fetched_instruction (fetched_instruction),
    .pc                  (pc),
    .instr               (instr),
    .instr_pc            (instr_pc),
    .instr_valid         (instr_valid),
    .halted              (halted),
    .fetch_count         (fetch_count),
`ifdef FETCH_BOUNDS_CHECK_EN
    .fault               (fault),
`endif
    .fsm_state           (fsm_state)
  );

  // Program image: HALT at address 5, otherwise a pc-dependent non-HALT word.
  function automatic logic [39:0] word_at(input logic [15:0] a);
    if (a == 16'd5) return 40'hFF00000000;
    return {8'h01, 16'hC0DE, a ^ 16'h5A5A};
  endfunction

  always_comb fetched_instruction = word_at(pc);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic push_exp(input logic v, input logic [15:0] ipc, input logic [39:0] ins);
    exp_q.push_back({v, ipc, ins});
  endtask

  task automatic pop_check(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got empty queue required entry", tag);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, ".valid"}, 64'(instr_valid), 64'(e[56]));
    if (e[56]) begin
      chk({tag, ".instr_pc"}, 64'(instr_pc), 64'(e[55:40]));
      chk({tag, ".instr"}, 64'(instr), 64'(e[39:0]));
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    #12;
    chk("rst.pc", 64'(pc), 64'h0);
    chk("rst.instr", 64'(instr), 64'h0);
    chk("rst.instr_pc", 64'(instr_pc), 64'h0);
    chk("rst.valid", 64'(instr_valid), 64'h0);
    chk("rst.halted", 64'(halted), 64'h0);
    chk("rst.count", 64'(fetch_count), 64'h0);
    chk("rst.state", 64'(fsm_state), 64'h0);
    reset = 1'b1;

    // BOOT bubble, then A/B at pc 0/1
    push_exp(1'b0, 16'd0, 40'd0); tick(); pop_check("boot");
    chk("boot.pc", 64'(pc), 64'h0);
    push_exp(1'b1, 16'd0, word_at(16'd0)); tick(); pop_check("fetch0");
    push_exp(1'b1, 16'd1, word_at(16'd1)); tick(); pop_check("fetch1");

    // stall three cycles while B is presented
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b1, 16'd1, word_at(16'd1)); tick(); pop_check("stall");
      chk("stall.pc", 64'(pc), 64'h2);
      chk("stall.count", 64'(fetch_count), 64'h2);
    end
    stall = 1'b0;
    push_exp(1'b1, 16'd2, word_at(16'd2)); tick(); pop_check("fetch2");
    chk("fetch2.count", 64'(fetch_count), 64'h3);
    chk("fetch2.pc", 64'(pc), 64'h3);

    // redirect beats stall
    redirect_valid = 1'b1; redirect_pc = 16'h0040; stall = 1'b1;
    push_exp(1'b0, 16'd0, 40'd0); tick(); pop_check("flush40");
    chk("flush40.pc", 64'(pc), 64'h40);
    chk("flush40.count", 64'(fetch_count), 64'h3);
    redirect_valid = 1'b0; stall = 1'b0;
    push_exp(1'b1, 16'h0040, word_at(16'h0040)); tick(); pop_check("tgt40");
    chk("tgt40.count", 64'(fetch_count), 64'h4);

    // run into HALT at 5
    redirect_valid = 1'b1; redirect_pc = 16'd3;
    push_exp(1'b0, 16'd0, 40'd0); tick(); pop_check("flush3");
    redirect_valid = 1'b0;
    push_exp(1'b1, 16'd3, word_at(16'd3)); tick(); pop_check("fetch3");
    push_exp(1'b1, 16'd4, word_at(16'd4)); tick(); pop_check("fetch4");
    push_exp(1'b1, 16'd5, 40'hFF00000000); tick(); pop_check("halt");
    chk("halt.halted", 64'(halted), 64'h1);
    chk("halt.pc", 64'(pc), 64'h5);
    chk("halt.count", 64'(fetch_count), 64'h7);
    stall = 1'b1;
    push_exp(1'b1, 16'd5, 40'hFF00000000); tick(); pop_check("halt_stall");
    stall = 1'b0;
    push_exp(1'b0, 16'd0, 40'd0); tick(); pop_check("halted_idle");
    chk("halted_idle.pc", 64'(pc), 64'h5);
    chk("halted_idle.halted", 64'(halted), 64'h1);
    chk("halted_idle.count", 64'(fetch_count), 64'h7);

    // resume from HALT
    redirect_valid = 1'b1; redirect_pc = 16'd0;
    push_exp(1'b0, 16'd0, 40'd0); tick(); pop_check("resume");
    chk("resume.halted", 64'(halted), 64'h0);
    chk("resume.pc", 64'(pc), 64'h0);
    redirect_valid = 1'b0;
    push_exp(1'b1, 16'd0, word_at(16'd0)); tick(); pop_check("resume0");
    chk("resume0.count", 64'(fetch_count), 64'h8);

`ifdef FETCH_BOUNDS_CHECK_EN
    redirect_valid = 1'b1; redirect_pc = 16'd253;
    push_exp(1'b0, 16'd0, 40'd0); tick(); pop_check("flush253");
    redirect_valid = 1'b0;
    push_exp(1'b1, 16'd253, word_at(16'd253)); tick(); pop_check("fetch253");
    push_exp(1'b1, 16'd254, word_at(16'd254)); tick(); pop_check("fetch254");
    chk("fetch254.pc", 64'(pc), 64'd255);
    push_exp(1'b0, 16'd0, 40'd0); tick(); pop_check("fault");
    chk("fault.fault", 64'(fault), 64'h1);
    chk("fault.pc", 64'(pc), 64'd255);
    chk("fault.count", 64'(fetch_count), 64'd10);
    redirect_valid = 1'b1; redirect_pc = 16'd0;
    push_exp(1'b0, 16'd0, 40'd0); tick(); pop_check("unfault");
    chk("unfault.fault", 64'(fault), 64'h0);
    chk("unfault.pc", 64'(pc), 64'h0);
    redirect_valid = 1'b0;
`else
    redirect_valid = 1'b1; redirect_pc = 16'hFFFF;
    push_exp(1'b0, 16'd0, 40'd0); tick(); pop_check("flushffff");
    redirect_valid = 1'b0;
    push_exp(1'b1, 16'hFFFF, word_at(16'hFFFF)); tick(); pop_check("fetchffff");
    chk("wrap.pc", 64'(pc), 64'h0);
    chk("wrap.count", 64'(fetch_count), 64'd9);
`endif

    // asynchronous reset between edges
    tick();
    reset = 1'b0;
    #2;
    chk("areset.pc", 64'(pc), 64'h0);
    chk("areset.valid", 64'(instr_valid), 64'h0);
    chk("areset.count", 64'(fetch_count), 64'h0);
    chk("areset.state", 64'(fsm_state), 64'h0);
    #1;
    reset = 1'b1;
    push_exp(1'b0, 16'd0, 40'd0); tick(); pop_check("reboot");
    push_exp(1'b1, 16'd0, word_at(16'd0)); tick(); pop_check("refetch0");
    chk("refetch0.count", 64'(fetch_count), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
